// File: rtl/ps2_key_tracker.sv
// PS/2 scan-code decoder: pops bytes from the keyboard FIFO, decodes E0/F0 prefixes and
// tracks up to SLOTS held keys, reporting new makes and breaks as one-cycle pulses.
module ps2_key_tracker #(
  parameter int unsigned SLOTS         = 4,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned REPEAT_FILTER = 1
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [7:0]       data,
  input  logic             ready,
  input  logic             overflow,
  output logic             nextdata_n,
  output logic [7:0]       key_code,
  output logic             key_ext,
  output logic             key_make,
  output logic             key_break,
  output logic [CNT_W-1:0] press_count,
  output logic [3:0]       held_count,
  output logic             held_any,
  output logic             table_ovf,
  output logic             fifo_ovf
);

  localparam logic [1:0] PhFetch = 2'd0;
  localparam logic [1:0] PhPop   = 2'd1;
  localparam logic [1:0] PhWait  = 2'd2;

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StExt    = 2'd1;
  localparam logic [1:0] StBrk    = 2'd2;
  localparam logic [1:0] StExtBrk = 2'd3;

  logic [1:0]       ph_q, st_q, st_d;
  logic [7:0]       byte_q;
  logic             pop_n_q;
  logic [SLOTS-1:0] valid_q, valid_d;
  logic [8:0]       key_q [SLOTS];
  logic [8:0]       key_d [SLOTS];
  logic [7:0]       code_q, code_d;
  logic             ext_q, ext_d;
  logic             make_q, make_d, brk_q, brk_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tovf_q, tovf_d, fovf_q;

  logic             ev_make, ev_brk, ev_ext, hit, full;
  logic [8:0]       lookup;
  logic [SLOTS-1:0] match, free_oh;

  // Prefix decoder; st_d is only committed when a byte is being consumed.
  always_comb begin
    st_d    = st_q;
    ev_make = 1'b0;
    ev_brk  = 1'b0;
    ev_ext  = 1'b0;
    case (st_q)
      StIdle: begin
        if (byte_q == 8'hE0) st_d = StExt;
        else if (byte_q == 8'hF0) st_d = StBrk;
        else if (!(byte_q inside {8'hAA, 8'hFA, 8'hFE, 8'hE1, 8'h00, 8'hFF})) ev_make = 1'b1;
      end
      StExt: begin
        if (byte_q == 8'hF0) st_d = StExtBrk;
        else if (byte_q != 8'hE0) begin
          ev_make = 1'b1;
          ev_ext  = 1'b1;
          st_d    = StIdle;
        end
      end
      StBrk: begin
        if (byte_q == 8'hE0) st_d = StExtBrk;
        else if (byte_q != 8'hF0) begin
          ev_brk = 1'b1;
          st_d   = StIdle;
        end
      end
      default: begin
        if (byte_q != 8'hE0 && byte_q != 8'hF0) begin
          ev_brk = 1'b1;
          ev_ext = 1'b1;
          st_d   = StIdle;
        end
      end
    endcase
  end

  assign lookup = {ev_ext, byte_q};

  // Keys are unique in the table, so match is at most one-hot.
  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      match[i] = valid_q[i] && (key_q[i] == lookup);
    end
  end

  assign hit     = |match;
  assign full    = &valid_q;
  assign free_oh = ~valid_q & (valid_q + SLOTS'(1));

  always_comb begin
    valid_d = valid_q;
    key_d   = key_q;
    make_d  = 1'b0;
    brk_d   = 1'b0;
    code_d  = code_q;
    ext_d   = ext_q;
    cnt_d   = cnt_q;
    tovf_d  = tovf_q;
    if (ph_q == PhPop) begin
      if (ev_make) begin
        if (!hit || REPEAT_FILTER == 0) begin
          make_d = 1'b1;
          code_d = byte_q;
          ext_d  = ev_ext;
        end
        if (!hit) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (full) begin
            tovf_d = 1'b1;
          end else begin
            valid_d = valid_q | free_oh;
            for (int i = 0; i < SLOTS; i++) begin
              if (free_oh[i]) key_d[i] = lookup;
            end
          end
        end
      end else if (ev_brk) begin
        valid_d = valid_q & ~match;
        brk_d   = 1'b1;
        code_d  = byte_q;
        ext_d   = ev_ext;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      ph_q    <= PhFetch;
      st_q    <= StIdle;
      byte_q  <= 8'h00;
      pop_n_q <= 1'b1;
      valid_q <= '0;
      for (int i = 0; i < SLOTS; i++) key_q[i] <= 9'h000;
      code_q  <= 8'h00;
      ext_q   <= 1'b0;
      make_q  <= 1'b0;
      brk_q   <= 1'b0;
      cnt_q   <= '0;
      tovf_q  <= 1'b0;
      fovf_q  <= 1'b0;
    end else begin
      case (ph_q)
        PhFetch: begin
          if (ready) begin
            ph_q    <= PhPop;
            byte_q  <= data;
            pop_n_q <= 1'b0;
          end
        end
        PhPop: begin
          ph_q    <= PhWait;
          pop_n_q <= 1'b1;
          st_q    <= st_d;
        end
        default: ph_q <= PhFetch;
      endcase
      valid_q <= valid_d;
      key_q   <= key_d;
      code_q  <= code_d;
      ext_q   <= ext_d;
      make_q  <= make_d;
      brk_q   <= brk_d;
      cnt_q   <= cnt_d;
      tovf_q  <= tovf_d;
      fovf_q  <= fovf_q | overflow;
    end
  end

  always_comb begin
    held_count = 4'd0;
    for (int i = 0; i < SLOTS; i++) held_count = held_count + 4'(valid_q[i]);
  end

  assign held_any    = (held_count != 4'd0);
  assign nextdata_n  = pop_n_q;
  assign key_code    = code_q;
  assign key_ext     = ext_q;
  assign key_make    = make_q;
  assign key_break   = brk_q;
  assign press_count = cnt_q;
  assign table_ovf   = tovf_q;
  assign fifo_ovf    = fovf_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker: a byte table against the default build, with
// no-filter and 4-bit-counter variants fed the same stream, plus hand-written corner cases.
module tb_ps2_key_tracker;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic [7:0] data = 8'h00;
  logic       ready = 1'b0;
  logic       overflow = 1'b0;

  logic       nd_n, ext, mk, brk, hany, tovf, fovf;
  logic [7:0] code, press;
  logic [3:0] held;

  logic       nf_nd_n, nf_ext, nf_mk, nf_brk, nf_hany, nf_tovf, nf_fovf;
  logic [7:0] nf_code, nf_press;
  logic [3:0] nf_held;

  logic       c4_nd_n, c4_ext, c4_mk, c4_brk, c4_hany, c4_tovf, c4_fovf;
  logic [7:0] c4_code;
  logic [3:0] c4_press, c4_held;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ps2_key_tracker dut (
    .clk(clk), .clr(clr), .data(data), .ready(ready), .overflow(overflow),
    .nextdata_n(nd_n), .key_code(code), .key_ext(ext), .key_make(mk), .key_break(brk),
    .press_count(press), .held_count(held), .held_any(hany), .table_ovf(tovf),
    .fifo_ovf(fovf)
  );

  ps2_key_tracker #(.REPEAT_FILTER(0)) dut_nf (
    .clk(clk), .clr(clr), .data(data), .ready(ready), .overflow(overflow),
    .nextdata_n(nf_nd_n), .key_code(nf_code), .key_ext(nf_ext), .key_make(nf_mk),
    .key_break(nf_brk), .press_count(nf_press), .held_count(nf_held), .held_any(nf_hany),
    .table_ovf(nf_tovf), .fifo_ovf(nf_fovf)
  );

  ps2_key_tracker #(.CNT_W(4)) dut_c4 (
    .clk(clk), .clr(clr), .data(data), .ready(ready), .overflow(overflow),
    .nextdata_n(c4_nd_n), .key_code(c4_code), .key_ext(c4_ext), .key_make(c4_mk),
    .key_break(c4_brk), .press_count(c4_press), .held_count(c4_held), .held_any(c4_hany),
    .table_ovf(c4_tovf), .fifo_ovf(c4_fovf)
  );

  typedef struct {
    logic [7:0] b;
    logic       mk;
    logic       mk_nf;
    logic       brk;
    logic [7:0] code;
    logic       ext;
    logic [7:0] press;
    logic [3:0] held;
    logic       tovf;
  } vec_t;

  vec_t vec [22];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Offer one byte, wait for its pop, then sample the WAIT cycle where the event shows.
  task automatic send(input logic [7:0] b);
    bit popped = 1'b0;
    data  = b;
    ready = 1'b1;
    for (int k = 0; k < 8 && !popped; k++) begin
      @(negedge clk);
      if (nd_n == 1'b0) popped = 1'b1;
    end
    ready = 1'b0;
    if (!popped) begin
      checks++;
      failures++;
      $display("FAIL pop_timeout: got no pop expected pop for byte %0h", b);
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
  endtask

  initial begin
    vec[0]  = '{8'h1C, 1, 1, 0, 8'h1C, 0, 8'd1, 4'd1, 0};
    vec[1]  = '{8'hF0, 0, 0, 0, 8'h1C, 0, 8'd1, 4'd1, 0};
    vec[2]  = '{8'h1C, 0, 0, 1, 8'h1C, 0, 8'd1, 4'd0, 0};
    vec[3]  = '{8'hE0, 0, 0, 0, 8'h1C, 0, 8'd1, 4'd0, 0};
    vec[4]  = '{8'h75, 1, 1, 0, 8'h75, 1, 8'd2, 4'd1, 0};
    vec[5]  = '{8'hE0, 0, 0, 0, 8'h75, 1, 8'd2, 4'd1, 0};
    vec[6]  = '{8'hF0, 0, 0, 0, 8'h75, 1, 8'd2, 4'd1, 0};
    vec[7]  = '{8'h75, 0, 0, 1, 8'h75, 1, 8'd2, 4'd0, 0};
    vec[8]  = '{8'h1C, 1, 1, 0, 8'h1C, 0, 8'd3, 4'd1, 0};
    vec[9]  = '{8'h1C, 0, 1, 0, 8'h1C, 0, 8'd3, 4'd1, 0};
    vec[10] = '{8'h1C, 0, 1, 0, 8'h1C, 0, 8'd3, 4'd1, 0};
    vec[11] = '{8'hAA, 0, 0, 0, 8'h1C, 0, 8'd3, 4'd1, 0};
    vec[12] = '{8'hF0, 0, 0, 0, 8'h1C, 0, 8'd3, 4'd1, 0};
    vec[13] = '{8'h1C, 0, 0, 1, 8'h1C, 0, 8'd3, 4'd0, 0};
    vec[14] = '{8'h15, 1, 1, 0, 8'h15, 0, 8'd4, 4'd1, 0};
    vec[15] = '{8'h1D, 1, 1, 0, 8'h1D, 0, 8'd5, 4'd2, 0};
    vec[16] = '{8'h24, 1, 1, 0, 8'h24, 0, 8'd6, 4'd3, 0};
    vec[17] = '{8'h2D, 1, 1, 0, 8'h2D, 0, 8'd7, 4'd4, 0};
    vec[18] = '{8'h2C, 1, 1, 0, 8'h2C, 0, 8'd8, 4'd4, 1};
    vec[19] = '{8'hF0, 0, 0, 0, 8'h2C, 0, 8'd8, 4'd4, 1};
    vec[20] = '{8'h1D, 0, 0, 1, 8'h1D, 0, 8'd8, 4'd3, 1};
    vec[21] = '{8'h2C, 1, 1, 0, 8'h2C, 0, 8'd9, 4'd4, 1};

    // Reset with ready high: no pop may issue while clr is held.
    clr   = 1'b1;
    ready = 1'b1;
    data  = 8'h1C;
    @(negedge clk);
    @(negedge clk);
    chk("rst_nextdata_n", 32'(nd_n), 32'd1);
    chk("rst_code", 32'(code), 32'h00);
    chk("rst_ext_make_break", 32'({ext, mk, brk}), 32'd0);
    chk("rst_press", 32'(press), 32'd0);
    chk("rst_held", 32'({held, hany}), 32'd0);
    chk("rst_ovf", 32'({tovf, fovf}), 32'd0);
    ready = 1'b0;
    clr   = 1'b0;

    for (int i = 0; i < 22; i++) begin
      send(vec[i].b);
      chk($sformatf("v%0d_make", i), 32'(mk), 32'(vec[i].mk));
      chk($sformatf("v%0d_break", i), 32'(brk), 32'(vec[i].brk));
      chk($sformatf("v%0d_code", i), 32'(code), 32'(vec[i].code));
      chk($sformatf("v%0d_ext", i), 32'(ext), 32'(vec[i].ext));
      chk($sformatf("v%0d_press", i), 32'(press), 32'(vec[i].press));
      chk($sformatf("v%0d_held", i), 32'(held), 32'(vec[i].held));
      chk($sformatf("v%0d_held_any", i), 32'(hany), 32'(vec[i].held != 4'd0));
      chk($sformatf("v%0d_table_ovf", i), 32'(tovf), 32'(vec[i].tovf));
      chk($sformatf("v%0d_nf_make", i), 32'(nf_mk), 32'(vec[i].mk_nf));
      chk($sformatf("v%0d_nf_press", i), 32'(nf_press), 32'(vec[i].press));
      chk($sformatf("v%0d_c4_press", i), 32'(c4_press), 32'(vec[i].press[3:0]));
    end

    // Broken 1D freed slot 1; the retried 2C must land there.
    chk("slot_reuse_valid", 32'(dut.valid_q), 32'hF);
    chk("slot_reuse_key", 32'(dut.key_q[1]), 32'h02C);

    @(negedge clk);
    chk("pulse_one_cycle", 32'({mk, brk}), 32'd0);

    overflow = 1'b1;
    @(negedge clk);
    overflow = 1'b0;
    chk("fifo_ovf_set", 32'(fovf), 32'd1);
    repeat (3) @(negedge clk);
    chk("fifo_ovf_sticky", 32'(fovf), 32'd1);

    // Reset after an F0 prefix: the following 1C is a make.
    send(8'hF0);
    do_reset();
    chk("mid_rst_fifo_ovf", 32'(fovf), 32'd0);
    chk("mid_rst_table_ovf", 32'(tovf), 32'd0);
    send(8'h1C);
    chk("mid_rst_make", 32'(mk), 32'd1);
    chk("mid_rst_break", 32'(brk), 32'd0);
    chk("mid_rst_held", 32'(held), 32'd1);
    chk("mid_rst_press", 32'(press), 32'd1);

    // 17 distinct make/break pairs: the 4-bit counter wraps to 1.
    do_reset();
    for (int i = 0; i < 17; i++) begin
      send(8'h30 + 8'(i));
      send(8'hF0);
      send(8'h30 + 8'(i));
    end
    chk("wrap_c4_press", 32'(c4_press), 32'd1);
    chk("wrap_press", 32'(press), 32'd17);
    chk("wrap_held", 32'(held), 32'd0);
    chk("wrap_last_break", 32'({brk, code}), 32'h140);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
